pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/pc_next_sel.sv | 48 ++++
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer (exception support gated by PC_SEQ_EPC_EN).
// Holds the address width, the sequencer state encoding and the default reset/step/vector values.
package pc_seq_pkg;

    localparam int PC_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam logic [PC_W-1:0] DEF_RESET_PC  = 16'h0000;
    localparam logic [PC_W-1:0] DEF_PC_STEP   = 16'h0002;
    localparam logic [PC_W-1:0] EXC_VECTOR    = 16'h0002;
    localparam logic [PC_W-1:0] PC_ALIGN_MASK = 16'hFFFE;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: halt > siic > rti > redirect > stall > increment (siic/rti only with PC_SEQ_EPC_EN).
// Latency: purely combinational; backpressure: stall holds pc unless a higher-priority event applies.
module pc_next_sel
    import pc_seq_pkg::*;
(
    input  logic            run,
    input  logic            halt,
    input  logic            redirect,
    input  logic            stall,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] pc_inc,
    input  logic [PC_W-1:0] redirect_pc,
`ifdef PC_SEQ_EPC_EN
    input  logic            siic,
    input  logic            rti,
    input  logic [PC_W-1:0] epc,
    output logic            epc_load,
`endif
    output logic [PC_W-1:0] pc_next,
    output logic            halt_take
);

    always_comb begin
        pc_next   = pc;
        halt_take = 1'b0;
`ifdef PC_SEQ_EPC_EN
        epc_load  = 1'b0;
`endif
        // Outside RUN every input is ignored and pc holds.
        if (run) begin
            if (halt) begin
                halt_take = 1'b1;
`ifdef PC_SEQ_EPC_EN
            end else if (siic) begin
                pc_next  = EXC_VECTOR;
                epc_load = 1'b1;
            end else if (rti) begin
                pc_next = epc;
`endif
            end else if (redirect) begin
                pc_next = redirect_pc & PC_ALIGN_MASK;
            end else if (!stall) begin
                pc_next = pc_inc;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with IDLE/RUN/HALTED control; optional exception save/return via PC_SEQ_EPC_EN.
// Latency: inputs sampled at an edge show on pc right after it; backpressure: stall holds pc.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [PC_W-1:0] PC_STEP  = DEF_PC_STEP
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            halt,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
`ifdef PC_SEQ_EPC_EN
    input  logic            siic,
    input  logic            rti,
    output logic [PC_W-1:0] epc,
`endif
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_inc,
    output logic            fetch_valid,
    output logic            halted
);

    pc_state_t       state;
    pc_state_t       state_next;
    logic [PC_W-1:0] pc_next;
    logic            halt_take;
    logic            run;

    assign run         = (state == RUN);
    assign fetch_valid = run;
    assign pc_inc      = pc + PC_STEP;

`ifdef PC_SEQ_EPC_EN
    logic epc_load;
`endif

    pc_next_sel u_next_sel (
        .run         (run),
        .halt        (halt),
        .redirect    (redirect),
        .stall       (stall),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .redirect_pc (redirect_pc),
`ifdef PC_SEQ_EPC_EN
        .siic        (siic),
        .rti         (rti),
        .epc         (epc),
        .epc_load    (epc_load),
`endif
        .pc_next     (pc_next),
        .halt_take   (halt_take)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     if (halt_take) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            pc     <= pc_next;
            halted <= (state_next == HALTED);
        end
    end

`ifdef PC_SEQ_EPC_EN
    // Return address is the instruction after the one taking the exception.
    always_ff @(posedge clk) begin
        if (rst) begin
            epc <= '0;
        end else if (epc_load) begin
            epc <= pc_inc;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a rule-level model.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

`ifdef PC_SEQ_EPC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        siic = 1'b0;
    logic        rti = 1'b0;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic        fetch_valid;
    logic        halted;
`ifdef PC_SEQ_EPC_EN
    logic [15:0] epc;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_epc = 16'h0000;
    bit          m_started = 1'b0;
    bit          m_stopped = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
`ifdef PC_SEQ_EPC_EN
        .siic        (siic),
        .rti         (rti),
        .epc         (epc),
`endif
        .pc          (pc),
        .pc_inc      (pc_inc),
        .fetch_valid (fetch_valid),
        .halted      (halted)
    );

    // Rule-level model: one call per rising edge using the inputs present at that edge.
    function automatic void model_step();
        if (rst) begin
            m_pc = 16'h0000; m_epc = 16'h0000; m_started = 1'b0; m_stopped = 1'b0;
        end else if (m_stopped) begin
            m_pc = m_pc;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (halt) begin
            m_stopped = 1'b1;
        end else if (EXC_EN && siic) begin
            m_epc = 16'(m_pc + 16'd2);
            m_pc  = 16'h0002;
        end else if (EXC_EN && rti) begin
            m_pc = m_epc;
        end else if (redirect) begin
            m_pc = {redirect_pc[15:1], 1'b0};
        end else if (!stall) begin
            m_pc = 16'(m_pc + 16'd2);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; stall = 1'b0; halt = 1'b0; redirect = 1'b0;
        redirect_pc = 16'h0000; siic = 1'b0; rti = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'($urandom_range(0, 1)); halt = 1'b1; redirect = 1'b1;
        redirect_pc = 16'($urandom); siic = 1'b1; rti = 1'($urandom_range(0, 1));
        tick(); tick();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc actual=%h expected=%h", pc, 16'h0000); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid actual=%b expected=0", fetch_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted actual=%b expected=0", halted); end
`ifdef PC_SEQ_EPC_EN
        checks++; if (epc !== 16'h0000) begin errors++; $display("FAIL reset_epc actual=%h expected=0000", epc); end
`endif
        // Leaving reset: IDLE ignores halt/redirect, then RUN starts from the reset pc.
        clear_inputs(); halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h1234;
        tick();
        clear_inputs();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL idle_ignores_pc actual=%h expected=0000", pc); end
        checks++; if (fetch_valid !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL idle_ignores_state actual fv=%b halted=%b expected fv=1 halted=0", fetch_valid, halted);
        end
    endtask

    task automatic test_free_run();
        logic [15:0] exp_pc [5] = '{16'h0000, 16'h0000, 16'h0002, 16'h0004, 16'h0006};
        logic        exp_fv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        clear_inputs(); rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++; if (pc !== exp_pc[i]) begin errors++; $display("FAIL free_run_pc[%0d] actual=%h expected=%h", i, pc, exp_pc[i]); end
            checks++; if (fetch_valid !== exp_fv[i]) begin errors++; $display("FAIL free_run_fv[%0d] actual=%b expected=%b", i, fetch_valid, exp_fv[i]); end
        end
    endtask

    task automatic test_redirect_stall();
        clear_inputs(); redirect = 1'b1; redirect_pc = 16'h0010;
        tick();
        checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL redirect_pc actual=%h expected=0010", pc); end
        stall = 1'b1; redirect_pc = 16'h0123;
        tick();
        clear_inputs();
        checks++; if (pc !== 16'h0122) begin errors++; $display("FAIL redirect_over_stall actual=%h expected=0122", pc); end
    endtask

    task automatic test_wrap();
        clear_inputs(); redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        clear_inputs();
        checks++; if (pc_inc !== 16'h0000) begin errors++; $display("FAIL wrap_pc_inc actual=%h expected=0000", pc_inc); end
        tick();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc actual=%h expected=0000", pc); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 16'h0000 || fetch_valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d] actual pc=%h fv=%b expected pc=0000 fv=1", i, pc, fetch_valid);
            end
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        clear_inputs(); redirect = 1'b1; redirect_pc = 16'h0020;
        tick();
        clear_inputs(); halt = 1'b1;
        tick();
        clear_inputs();
        checks++; if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 16'h0020) begin
            errors++; $display("FAIL halt_enter actual halted=%b fv=%b pc=%h expected halted=1 fv=0 pc=0020", halted, fetch_valid, pc);
        end
        for (int i = 0; i < 6; i++) begin
            redirect = 1'($urandom_range(0, 1)); stall = 1'($urandom_range(0, 1));
            siic = 1'b1; rti = 1'($urandom_range(0, 1)); redirect_pc = 16'($urandom);
            tick();
            checks++; if (pc !== 16'h0020 || halted !== 1'b1) begin
                errors++; $display("FAIL halt_frozen[%0d] actual pc=%h halted=%b expected pc=0020 halted=1", i, pc, halted);
            end
        end
        clear_inputs(); rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (pc !== 16'h0000 || halted !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL halt_reset actual pc=%h halted=%b fv=%b expected pc=0000 halted=0 fv=0", pc, halted, fetch_valid);
        end
        tick();
    endtask

    task automatic test_rst_priority();
        clear_inputs(); redirect = 1'b1; redirect_pc = 16'h0300;
        tick();
        rst = 1'b1; halt = 1'b1; redirect_pc = 16'h5556;
        tick();
        clear_inputs();
        checks++; if (pc !== 16'h0000 || halted !== 1'b0 || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL rst_priority actual pc=%h halted=%b fv=%b expected pc=0000 halted=0 fv=0", pc, halted, fetch_valid);
        end
        tick();
        checks++; if (pc !== 16'h0000 || fetch_valid !== 1'b1) begin
            errors++; $display("FAIL rst_idle_one_cycle actual pc=%h fv=%b expected pc=0000 fv=1", pc, fetch_valid);
        end
    endtask

`ifdef PC_SEQ_EPC_EN
    task automatic test_exception();
        clear_inputs(); redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        clear_inputs(); siic = 1'b1;
        tick();
        clear_inputs();
        checks++; if (pc !== 16'h0002 || epc !== 16'h0042) begin
            errors++; $display("FAIL siic actual pc=%h epc=%h expected pc=0002 epc=0042", pc, epc);
        end
        tick(); tick(); tick();
        checks++; if (pc !== 16'h0008) begin errors++; $display("FAIL exc_increment actual=%h expected=0008", pc); end
        rti = 1'b1; redirect = 1'b1; redirect_pc = 16'h0500;
        tick();
        clear_inputs();
        checks++; if (pc !== 16'h0042 || epc !== 16'h0042) begin
            errors++; $display("FAIL rti actual pc=%h epc=%h expected pc=0042 epc=0042", pc, epc);
        end
        siic = 1'b1; rti = 1'b1;
        tick();
        clear_inputs();
        checks++; if (pc !== 16'h0002 || epc !== 16'h0044) begin
            errors++; $display("FAIL siic_over_rti actual pc=%h epc=%h expected pc=0002 epc=0044", pc, epc);
        end
    endtask
`endif

    task automatic test_random();
        clear_inputs(); rst = 1'b1;
        tick();
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            halt        = ($urandom_range(0, 29) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 4) == 0);
            redirect_pc = 16'($urandom);
            siic        = ($urandom_range(0, 9) == 0);
            rti         = ($urandom_range(0, 9) == 0);
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rand_pc[%0d] actual=%h expected=%h", i, pc, m_pc); end
            checks++; if (pc_inc !== 16'(m_pc + 16'd2)) begin
                errors++; $display("FAIL rand_pc_inc[%0d] actual=%h expected=%h", i, pc_inc, 16'(m_pc + 16'd2));
            end
            checks++; if (fetch_valid !== (m_started && !m_stopped)) begin
                errors++; $display("FAIL rand_fv[%0d] actual=%b expected=%b", i, fetch_valid, (m_started && !m_stopped));
            end
            checks++; if (halted !== m_stopped) begin errors++; $display("FAIL rand_halted[%0d] actual=%b expected=%b", i, halted, m_stopped); end
`ifdef PC_SEQ_EPC_EN
            checks++; if (epc !== m_epc) begin errors++; $display("FAIL rand_epc[%0d] actual=%h expected=%h", i, epc, m_epc); end
`endif
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_redirect_stall();
        test_wrap();
        test_halt();
        test_rst_priority();
`ifdef PC_SEQ_EPC_EN
        test_exception();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
